// File: rtl/scomp_pkg.sv
// Shared types and constants for the serial two's-complement receiver.
package scomp_pkg;
  localparam int SCOMP_WIDTH = 4;
  typedef enum logic [1:0] {IDLE, SHIFT, FULL} state_e;
endpackage

// File: rtl/negate_bit.sv
// Copy-until-first-one negation cell: passes bits through until the first 1, then inverts.
module negate_bit (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic b,
  output logic nbit
);
  logic seen_q;
  logic seen_eff;

  // A frame's first bit must see seen=0 even though the register still holds the old frame.
  assign seen_eff = seen_q & ~clr;
  assign nbit     = b ^ seen_eff;

  always_ff @(posedge clk) begin
    if (rst)     seen_q <= 1'b0;
    else if (en) seen_q <= seen_eff | b;
  end
endmodule

// File: rtl/serial_compliment_rx.sv
// LSB-first serial receiver that negates each WIDTH-bit frame and presents it in parallel.
// Optional overflow flag output enabled by defining SCOMP_OVF_EN.
module serial_compliment_rx
  import scomp_pkg::*;
#(
  parameter int WIDTH = SCOMP_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             sin_first,
  output logic             sin_ready,
  output logic [WIDTH-1:0] out_word,
  output logic             out_valid,
  input  logic             out_ready
`ifdef SCOMP_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] asm_q, asm_d, asm_shift;
  logic [WIDTH-1:0] out_word_q, out_word_d;
  logic             out_valid_q, out_valid_d;
  logic             acc, nbit;
`ifdef SCOMP_OVF_EN
  logic             ovf_q, ovf_d;
  assign ovf = ovf_q;
`endif

  assign sin_ready = (state_q != FULL) | out_ready;
  assign acc       = sin_valid & sin_ready;
  assign asm_shift = {nbit, asm_q[WIDTH-1:1]};
  assign out_word  = out_word_q;
  assign out_valid = out_valid_q;

  negate_bit u_neg (
    .clk  (clk),
    .rst  (rst),
    .clr  (sin_first),
    .en   (acc),
    .b    (sin),
    .nbit (nbit)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    asm_d       = asm_q;
    out_word_d  = out_word_q;
    out_valid_d = out_valid_q;
`ifdef SCOMP_OVF_EN
    ovf_d       = ovf_q;
`endif
    case (state_q)
      IDLE: if (acc && sin_first) begin
        asm_d   = asm_shift;
        cnt_d   = CW'(1);
        state_d = SHIFT;
      end
      SHIFT: if (acc) begin
        asm_d = asm_shift;
        if (sin_first) begin
          cnt_d = CW'(1);
        end else if (cnt_q == LAST) begin
          out_word_d  = asm_shift;
          out_valid_d = 1'b1;
`ifdef SCOMP_OVF_EN
          // MSB set and nothing seen below it: the most-negative value negates to itself.
          ovf_d       = sin & nbit;
`endif
          cnt_d       = CW'(WIDTH);
          state_d     = FULL;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      FULL: if (out_ready) begin
        out_valid_d = 1'b0;
        if (acc && sin_first) begin
          asm_d   = asm_shift;
          cnt_d   = CW'(1);
          state_d = SHIFT;
        end else begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      asm_q       <= '0;
      out_word_q  <= '0;
      out_valid_q <= 1'b0;
`ifdef SCOMP_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      asm_q       <= asm_d;
      out_word_q  <= out_word_d;
      out_valid_q <= out_valid_d;
`ifdef SCOMP_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end
endmodule
